// File: rtl/mult_booth.sv
// Sequential signed 32x32 multiplier using radix-2 Booth recoding.
// One recoding step per clock; the 64-bit product appears on {HI,LO}
// 32 edges after the start edge, with a one-cycle done pulse.
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] mcand;
  logic [31:0] acc;
  logic [31:0] q;
  logic        qm1;
  logic [5:0]  cnt;

  logic [32:0] sum;
  logic [31:0] acc_nx;
  logic [31:0] q_nx;

  // One Booth step: add/subtract on a sign-extended 33-bit accumulator so
  // the shifted-in sign is the true sign even when the 32-bit sum wraps.
  always_comb begin
    sum = {acc[31], acc};
    case ({q[0], qm1})
      2'b01:   sum = {acc[31], acc} + {mcand[31], mcand};
      2'b10:   sum = {acc[31], acc} - {mcand[31], mcand};
      default: sum = {acc[31], acc};
    endcase
    acc_nx = sum[32:1];
    q_nx   = {sum[0], q[31:1]};
  end

  // Control FSM and datapath registers; HI/LO are only loaded on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            q     <= B;
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          q   <= q_nx;
          qm1 <= q[0];
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            HI    <= acc_nx;
            LO    <= q_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed corner cases plus randomized
// operands checked against a plain signed-multiply reference.
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  int unsigned n_chk;
  int unsigned n_pass;

  mult_booth dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Starts a multiply, scrambles inputs and pulses start while busy (an
  // extra start with A=2,B=2 always lands on edge 10), then waits for done.
  // Returns in the cycle where done is high.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prev;
    logic [63:0] exp;
    int cyc;
    prev = {HI, LO};
    exp  = ref_prod(a, b);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_done_after_start"}, 64'(done), 64'd0);
    cyc = 0;
    do begin
      if (cyc + 1 == 10) begin
        A = 32'd2;
        B = 32'd2;
        start = 1'b1;
      end else begin
        A = $urandom;
        B = $urandom;
        start = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
      if (!done && cyc < 32) begin
        check({tag, "_hold"}, {HI, LO}, prev);
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
      end
    end while (!done && cyc < 40);
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_product"}, {HI, LO}, exp);
  endtask

  initial begin
    logic [31:0] corners [6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] held;
    int dones;
    n_chk  = 0;
    n_pass = 0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h8000_0001;

    reset = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Directed products
    run_mult("a3b5", 32'd3, 32'd5);
    check("a3b5_const", {HI, LO}, 64'h0000_0000_0000_000F);
    tick();
    check("a3b5_done_drop", 64'(done), 64'd0);
    run_mult("m1x1", 32'hFFFF_FFFF, 32'd1);
    check("m1x1_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    run_mult("minxmin", 32'h8000_0000, 32'h8000_0000);
    check("minxmin_const", {HI, LO}, 64'h4000_0000_0000_0000);
    tick();
    run_mult("minx1", 32'h8000_0000, 32'd1);
    check("minx1_const", {HI, LO}, 64'hFFFF_FFFF_8000_0000);
    tick();
    run_mult("a7b6", 32'd7, 32'd6);
    check("a7b6_const", {HI, LO}, 64'd42);
    tick();

    // Reset in the middle of a multiply
    A = 32'd7;
    B = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_hilo_held", {HI, LO}, 64'd0);
    run_mult("a2bm3", 32'd2, 32'hFFFF_FFFD);
    check("a2bm3_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();

    // Back-to-back: second start in the done cycle of the first
    run_mult("b2b_first", 32'd9, 32'd11);
    held = {HI, LO};
    check("b2b_first_const", held, 64'd99);
    run_mult("b2b_second", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    check("b2b_second_const", {HI, LO}, 64'd16);
    tick();

    // Randomized operands with a bias toward boundary values
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_mult($sformatf("rnd%0d", i), ra, rb);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    check("final_done_low", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 The block SHALL provide these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a multiply
- A  input  32  multiplicand, two's complement
- B  input  32  multiplier, two's complement
- HI  output  32  upper word of the 64-bit product; feeds the register write-data select stage
- LO  output  32  lower word of the 64-bit product; feeds the register write-data select stage
- busy  output  1  multiply in progress
- done  output  1  one-cycle completion pulse
REQ-002 The block SHALL have no parameters; all widths are fixed at 32/64.

Function
REQ-003 The block SHALL compute the signed 64-bit product {HI,LO} = A*B using radix-2 Booth recoding, one recoding step per clock.
REQ-004 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-005 In IDLE, start=1 at a rising edge SHALL cause the following updates on that edge:
- latch A into the multiplicand register and B into the multiplier register
- clear the accumulator and the Q(-1) bit
- clear the 6-bit step counter
- set busy=1
- go to RUN
REQ-006 In RUN, each edge SHALL perform one Booth step:
- pair {Q0,Q-1}=01: add multiplicand to accumulator
- pair 10: subtract multiplicand from accumulator
- pair 00/11: no add or subtract
- then arithmetic-shift right the 65-bit {acc,Q,Q-1}
- increment the counter
REQ-007 Accumulator add/subtract SHALL be 32-bit and wrap; the sign for the arithmetic shift SHALL be taken from the 33-bit true result, so that the operand 0x80000000 is handled correctly.
REQ-008 On the edge that completes step 32, the block SHALL update the following:
- load HI<=acc and LO<=Q
- set done=1
- set busy=0
- return to IDLE
REQ-009 Latency SHALL be fixed at 32 edges after the start edge: done is high during the cycle after edge 32 and is low again after edge 33.
REQ-010 HI and LO SHALL change only at the completion edge (REQ-008) or at reset, and SHALL hold their last result otherwise; intermediate Booth state SHALL never be visible on HI or LO.
REQ-011 start SHALL be ignored while busy=1, and the operation in progress SHALL continue unaffected.
REQ-012 start=1 in the cycle in which done=1 SHALL be accepted, since the state is IDLE; the block SHALL support back-to-back multiplies with a 33-cycle period.
REQ-013 A and B SHALL be sampled only at the start edge, and later changes to them SHALL not affect the result.
REQ-014 done SHALL never be high in the same cycle as busy.

Reset
REQ-015 When reset=0, independent of clk, the block SHALL force the following:
- state to IDLE
- busy=0, done=0
- HI=0, LO=0
- accumulator, multiplier, multiplicand, Q-1 and counter to 0
REQ-016 Reset asserted during RUN SHALL abort the multiply with no done pulse and SHALL leave HI and LO at 0.
REQ-017 After reset deasserts, the first start SHALL behave as in REQ-005.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- A=3, B=5, start at edge 0 -> done high after edge 32 only; HI=0x00000000, LO=0x0000000F; busy high from after edge 0 through edge 32.
- A=0xFFFFFFFF (-1), B=0x00000001 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0x00000000; also A=0x80000000, B=0x00000001 -> HI=0xFFFFFFFF, LO=0x80000000.
- Start A=7, B=6; pulse start with A=2, B=2 at edge 10 -> ignored; result HI=0, LO=42 at edge 32.
- Start A=7, B=6; assert reset at cycle 15 -> busy=0, done=0, HI=LO=0 immediately; no done pulse follows; a new start A=2, B=-3 after release -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Back-to-back: second start (A=-4, B=-4) in the done cycle of the first -> second done 33 cycles after the first; HI=0, LO=16; the first result is held on HI/LO until then.
